// File: rtl/taint_mux_pipe.sv
// rtl/taint_mux_pipe.sv - N-way taint-tracking mux feeding a 2-entry valid/ready buffer
module taint_mux_pipe #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int T    = 32,
    parameter int MODE = 0,
    parameter int CW   = 16,
    localparam int SW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N*T-1:0] in_taint,
    input  logic [SW-1:0]  sel,
    input  logic [T-1:0]   sel_t,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [T-1:0]   out_taint,
    input  logic           clr_cnt,
    output logic [CW-1:0]  taint_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t         state_q, state_d;
    logic           push, pop;
    logic           sel_hit;
    logic [W-1:0]   mux_data, cap_data;
    logic [T-1:0]   mux_taint, any_taint, cap_taint;
    logic [W-1:0]   head_data, tail_data;
    logic [T-1:0]   head_taint, tail_taint;
    logic [CW-1:0]  cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // An out-of-range select is treated as maximally tainted with zero data.
    always_comb begin
        sel_hit   = 1'b0;
        mux_data  = '0;
        mux_taint = '0;
        any_taint = '0;
        for (int i = 0; i < N; i++) begin
            any_taint = any_taint | in_taint[i*T +: T];
            if (sel == SW'(i)) begin
                sel_hit   = 1'b1;
                mux_data  = in_data[i*W +: W];
                mux_taint = in_taint[i*T +: T];
            end
        end
        cap_data  = mux_data;
        cap_taint = '1;
        if (!sel_hit) begin
            cap_data = '0;
        end else if (MODE == 0) begin
            cap_taint = mux_taint | sel_t;
        end else if (sel_t == '0) begin
            cap_taint = mux_taint;
        end else begin
            cap_taint = sel_t | any_taint;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Ready/valid decode only from the state register, so in_ready never sees out_ready.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data  <= '0;
            head_taint <= '0;
            tail_data  <= '0;
            tail_taint <= '0;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    head_data  <= cap_data;
                    head_taint <= cap_taint;
                end
                ONE: begin
                    if (push && pop) begin
                        head_data  <= cap_data;
                        head_taint <= cap_taint;
                    end else if (push) begin
                        tail_data  <= cap_data;
                        tail_taint <= cap_taint;
                    end
                end
                FULL: if (pop) begin
                    head_data  <= tail_data;
                    head_taint <= tail_taint;
                end
                default: ;
            endcase
        end
    end

    assign out_data  = head_data;
    assign out_taint = head_taint;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_q <= '0;
        end else if (pop && (head_taint != '0) && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign taint_cnt = cnt_q;

endmodule

// File: tb/tb_taint_mux_pipe.sv
// tb/tb_taint_mux_pipe.sv - self-checking bench for taint_mux_pipe across four configurations
module tb_taint_mux_pipe;

    typedef struct {
        logic [7:0]  d;
        logic [31:0] t;
    } ent_t;

    logic         clk;
    logic         rst, in_valid, out_ready, clr_cnt;
    logic [31:0]  in_data_bus;
    logic [127:0] in_taint_bus;
    logic [1:0]   sel_bus;
    logic [31:0]  sel_t;

    logic [7:0]  od0, od1, od3;
    logic [0:0]  od2;
    logic [31:0] ot0, ot1, ot2, ot3;
    logic        ov0, ov1, ov2, ov3, ir0, ir1, ir2, ir3;
    logic [15:0] oc0, oc2, oc3;
    logic [1:0]  oc1;

    logic [7:0]  od [4];
    logic [31:0] ot [4];
    logic        ov [4];
    logic        ir [4];
    logic [15:0] oc [4];

    int tests = 0;
    int fails = 0;

    // Configurations: 0 = N4 MODE0, 1 = N4 MODE1 CW2, 2 = N2 W1 MODE0, 3 = N3 MODE0
    int          np   [4] = '{4, 4, 2, 3};
    int          md   [4] = '{0, 1, 0, 0};
    int unsigned cmax [4] = '{65535, 3, 65535, 65535};
    logic [7:0]  dmask[4] = '{8'hff, 8'hff, 8'h01, 8'hff};

    ent_t        q [4][$];
    int unsigned cnt [4];

    taint_mux_pipe #(.N(4), .W(8), .T(32), .MODE(0), .CW(16)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data_bus), .in_taint(in_taint_bus), .sel(sel_bus), .sel_t(sel_t),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_taint(ot0),
        .clr_cnt(clr_cnt), .taint_cnt(oc0));

    taint_mux_pipe #(.N(4), .W(8), .T(32), .MODE(1), .CW(2)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data_bus), .in_taint(in_taint_bus), .sel(sel_bus), .sel_t(sel_t),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_taint(ot1),
        .clr_cnt(clr_cnt), .taint_cnt(oc1));

    taint_mux_pipe #(.N(2), .W(1), .T(32), .MODE(0), .CW(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
        .in_data({in_data_bus[8], in_data_bus[0]}), .in_taint(in_taint_bus[63:0]),
        .sel(sel_bus[0]), .sel_t(sel_t),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_taint(ot2),
        .clr_cnt(clr_cnt), .taint_cnt(oc2));

    taint_mux_pipe #(.N(3), .W(8), .T(32), .MODE(0), .CW(16)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
        .in_data(in_data_bus[23:0]), .in_taint(in_taint_bus[95:0]), .sel(sel_bus), .sel_t(sel_t),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_taint(ot3),
        .clr_cnt(clr_cnt), .taint_cnt(oc3));

    assign od[0] = od0;  assign od[1] = od1;  assign od[2] = {7'b0, od2};  assign od[3] = od3;
    assign ot[0] = ot0;  assign ot[1] = ot1;  assign ot[2] = ot2;          assign ot[3] = ot3;
    assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;          assign ov[3] = ov3;
    assign ir[0] = ir0;  assign ir[1] = ir1;  assign ir[2] = ir2;          assign ir[3] = ir3;
    assign oc[0] = oc0;  assign oc[1] = {14'b0, oc1}; assign oc[2] = oc2; assign oc[3] = oc3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the selection rules say configuration k should capture from the current inputs.
    function automatic ent_t model_ent(input int k);
        int          n = np[k];
        int          s;
        logic [31:0] orall = '0;
        logic [31:0] tsel;
        ent_t        e;
        s = (n == 2) ? int'(sel_bus[0]) : int'(sel_bus);
        for (int i = 0; i < n; i++) orall = orall | in_taint_bus[i*32 +: 32];
        if (s >= n) begin
            e.d = 8'h00;
            e.t = 32'hffff_ffff;
        end else begin
            e.d  = in_data_bus[s*8 +: 8] & dmask[k];
            tsel = in_taint_bus[s*32 +: 32];
            if (md[k] == 0)       e.t = tsel | sel_t;
            else if (sel_t == 0)  e.t = tsel;
            else                  e.t = sel_t | orall;
        end
        return e;
    endfunction

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 64'(ov[k]), 64'd0);
            check($sformatf("%s_ready%0d", tag, k), 64'(ir[k]), 64'd1);
            check($sformatf("%s_cnt%0d", tag, k), 64'(oc[k]), 64'd0);
        end
    endtask

    // Compare every DUT against its queue model, then advance one clock edge.
    task automatic tick();
        ent_t ne [4];
        bit   pu [4];
        bit   po [4];
        bit   tp [4];
        for (int k = 0; k < 4; k++) begin
            check($sformatf("valid%0d", k), 64'(ov[k]), 64'(q[k].size() > 0));
            check($sformatf("ready%0d", k), 64'(ir[k]), 64'(q[k].size() < 2));
            check($sformatf("cnt%0d", k), 64'(oc[k]), 64'(cnt[k]));
            if (q[k].size() > 0) begin
                check($sformatf("data%0d", k), 64'(od[k]), 64'(q[k][0].d));
                check($sformatf("taint%0d", k), 64'(ot[k]), 64'(q[k][0].t));
            end
            ne[k] = model_ent(k);
            pu[k] = in_valid && (q[k].size() < 2);
            po[k] = out_ready && (q[k].size() > 0);
            tp[k] = po[k] && (q[k].size() > 0) && (q[k][0].t != 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                q[k].delete();
                cnt[k] = 0;
            end else begin
                if (po[k]) void'(q[k].pop_front());
                if (pu[k]) q[k].push_back(ne[k]);
                if (clr_cnt)                    cnt[k] = 0;
                else if (tp[k] && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        sel_bus = '0; sel_t = '0; in_data_bus = '0; in_taint_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            cnt[k] = 0;
            check($sformatf("rst_data%0d", k), 64'(od[k]), 64'd0);
            check($sformatf("rst_taint%0d", k), 64'(ot[k]), 64'd0);
        end
        check_reset_state("rst");
        rst = 1'b0;
        check("first_ready", 64'(ir[0]), 64'd1);

        // Mux/taint policy: a=0, b=1, a_t=1, b_t=2
        in_data_bus  = 32'h0000_0100;
        in_taint_bus = {64'h0, 32'h2, 32'h1};
        out_ready = 1'b1; in_valid = 1'b1;
        sel_bus = 2'd1; sel_t = 32'h4;
        tick();
        check("m0_sel1_valid", 64'(ov[2]), 64'd1);
        check("m0_sel1_data", 64'(od[2]), 64'd1);
        check("m0_sel1_taint", 64'(ot[2]), 64'h6);
        sel_bus = 2'd0;
        tick();
        check("m0_sel0_data", 64'(od[2]), 64'd0);
        check("m0_sel0_taint", 64'(ot[2]), 64'h5);
        check("m1_st4_sel0_taint", 64'(ot[1]), 64'h7);
        sel_bus = 2'd1; sel_t = 32'h0;
        tick();
        check("m1_st0_sel1_taint", 64'(ot[1]), 64'h2);
        in_valid = 1'b0;
        repeat (2) tick();

        // Backpressure
        out_ready = 1'b0; sel_bus = 2'd0; in_taint_bus = '0; in_valid = 1'b1;
        in_data_bus[7:0] = 8'h11; tick();
        in_data_bus[7:0] = 8'h22; tick();
        check("bp_full_ready", 64'(ir[0]), 64'd0);
        in_data_bus[7:0] = 8'h33; tick();
        check("bp_head_held", 64'(od[0]), 64'h11);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_second", 64'(od[0]), 64'h22);
        check("bp_ready_back", 64'(ir[0]), 64'd1);
        tick();
        check("bp_drained", 64'(ov[0]), 64'd0);

        // Streaming with alternating taint
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        in_valid = 1'b1; sel_t = '0;
        for (int i = 0; i < 8; i++) begin
            in_data_bus  = $urandom;
            in_taint_bus = (i % 2 == 1) ? {4{32'h8}} : 128'h0;
            sel_bus      = 2'($urandom_range(0, 3));
            tick();
            check($sformatf("stream_nobubble%0d", i), 64'(ov[0]), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("stream_cnt", 64'(oc[0]), 64'd4);
        check("sat_cnt", 64'(oc[1]), 64'd3);

        // Clear wins over a same-cycle tainted pop
        in_valid = 1'b1; in_taint_bus = {4{32'h1}}; sel_bus = 2'd0;
        tick();
        in_valid = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_wins0", 64'(oc[0]), 64'd0);
        check("clr_wins1", 64'(oc[1]), 64'd0);

        // Zero data keeps its taint
        in_data_bus = '0; in_taint_bus = {4{32'h40}}; sel_bus = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("zero_data", 64'(od[0]), 64'd0);
        check("zero_data_taint", 64'(ot[0]), 64'h40);
        tick();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid     = 1'($urandom_range(0, 1));
            out_ready    = ($urandom_range(0, 3) != 0);
            clr_cnt      = ($urandom_range(0, 15) == 0);
            in_data_bus  = $urandom;
            in_taint_bus = ($urandom_range(0, 2) == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
            sel_bus      = 2'($urandom_range(0, 3));
            sel_t        = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            tick();
        end
        clr_cnt = 1'b0;

        // Reset while full
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        check("pre_rst_full", 64'(ir[0]), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_reset_state("rst_full");
        in_data_bus[7:0] = 8'h5A; in_taint_bus = '0; sel_bus = 2'd0; sel_t = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_data", 64'(od[0]), 64'h5A);
        tick();
        check("post_rst_alone", 64'(ov[0]), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
